// File: rtl/step_cmd_ctrl_pkg.sv
// step_cmd_ctrl shared types and constants.
// Holds the sequencer state enum and the period/ramp constants.
package step_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int MIN_PERIOD = 2;
  localparam int RAMP_MULT  = 4;
  localparam int RAMP_SHIFT = 3;

endpackage

// File: rtl/step_cmd_ctrl_if.sv
// Command/step bus of step_cmd_ctrl.
// master: issues commands and abort; slave: the sequencer (step, dir, status).
interface step_cmd_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 20,
  parameter int POS_W = 24
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic             step;
  logic             dir;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [POS_W-1:0] position;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir,
    output cmd_period, abort,
    input  cmd_ready, step, dir, busy,
    input  done, aborted, position
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir,
    input  cmd_period, abort,
    output cmd_ready, step, dir, busy,
    output done, aborted, position
  );
endinterface

// File: rtl/step_cmd_ctrl_rate_div.sv
// step_rate_div: loadable down-counter, zero_o high while count is 0.
// Ports: clk, rest_n, load_i/load_val_i (reload), en_i (count), zero_o.
module step_rate_div #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rest_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/step_cmd_ctrl.sv
// step_cmd_ctrl: move-command sequencer producing step strobes + position.
// Ports: clk, rest_n, bus (slave); STEP_RAMP_EN adds an accel ramp.
module step_cmd_ctrl
  import step_cmd_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 20,
  parameter int POS_W = 24
) (
  input  logic           clk,
  input  logic           rest_n,
  step_cmd_ctrl_if.slave bus
);
  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [DIV_W-1:0] per_q;
  logic             dir_q;
  logic             aborted_q;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;

  logic [DIV_W-1:0] p_in;
  logic [DIV_W-1:0] cur_init;
  logic [DIV_W-1:0] cur_next;
  logic             tick;
  logic             accept;
  logic             step_c;
  logic             div_load;
  logic [DIV_W-1:0] div_val;

  assign p_in =
    (bus.cmd_period < DIV_W'(MIN_PERIOD)) ?
    DIV_W'(MIN_PERIOD) : bus.cmd_period;

`ifdef STEP_RAMP_EN
  localparam logic [DIV_W+1:0] RMAX =
    {2'b00, {DIV_W{1'b1}}};
  logic [DIV_W-1:0] cur_q;
  logic [DIV_W+1:0] p_mul;
  logic [DIV_W-1:0] cur_dec;

  // first interval is a stretched period, saturated to the field
  assign p_mul =
    (DIV_W+2)'(p_in) * (DIV_W+2)'(RAMP_MULT);
  assign cur_init =
    (p_mul > RMAX) ? {DIV_W{1'b1}} : p_mul[DIV_W-1:0];
  // shrink by 1/8 per step, never below the cruise period
  assign cur_dec  = cur_q - (cur_q >> RAMP_SHIFT);
  assign cur_next = (cur_dec < per_q) ? per_q : cur_dec;
`else
  assign cur_init = p_in;
  assign cur_next = per_q;
`endif

  assign accept = (state_q == IDLE) && bus.cmd_valid;
  assign step_c = (state_q == RUN) && tick && !bus.abort;
  assign pos_d  = dir_q ? pos_q + POS_W'(1)
                        : pos_q - POS_W'(1);

  assign div_load = accept || ((state_q == RUN) && tick);
  assign div_val  = (state_q == IDLE) ?
                    cur_init - DIV_W'(1) :
                    cur_next - DIV_W'(1);

  step_rate_div #(.W(DIV_W)) u_div (
    .clk        (clk),
    .rest_n     (rest_n),
    .load_i     (div_load),
    .load_val_i (div_val),
    .en_i       (state_q == RUN),
    .zero_o     (tick)
  );

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      per_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      pos_q     <= '0;
`ifdef STEP_RAMP_EN
      cur_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            dir_q     <= bus.cmd_dir;
            rem_q     <= bus.cmd_steps;
            per_q     <= p_in;
            aborted_q <= 1'b0;
`ifdef STEP_RAMP_EN
            cur_q     <= cur_init;
`endif
            state_q <= (bus.cmd_steps == '0) ?
                       DONE : RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else if (tick) begin
            rem_q <= rem_q - CNT_W'(1);
            pos_q <= pos_d;
`ifdef STEP_RAMP_EN
            cur_q <= cur_next;
`endif
            if (rem_q == CNT_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.step      = step_c;
  assign bus.dir       = dir_q;
  assign bus.aborted   = aborted_q;
  assign bus.position  = pos_q;
endmodule

// File: doc/step_cmd_ctrl.md
# step_cmd_ctrl

Step-command sequencer that sits directly upstream of the stepper-motor phase controller. It accepts move commands (step count, direction, step period) over a valid/ready handshake and produces single-cycle step strobes plus a stable direction level. The downstream phase controller consumes these and advances one phase per strobe. The block also tracks absolute motor position and reports completion or abort.

## Interface
Parameters:
- CNT_W, 16, width of the step-count field
- DIV_W, 20, width of the step-period field (clock cycles per step)
- POS_W, 24, width of the signed position counter

Ports:
- clk  in  1  system clock, rising edge
- rest_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_steps  in  CNT_W  number of steps to issue (unsigned)
- cmd_dir  in  1  direction: 1 = forward, 0 = reverse
- cmd_period  in  DIV_W  clock cycles between steps; values below 2 are clamped to 2
- abort  in  1  stop the current move
- step  out  1  one-cycle step strobe to the phase controller
- dir  out  1  latched direction, stable while busy
- busy  out  1  move in progress (RUN or DONE)
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with done; 1 when the move ended by abort
- position  out  POS_W  signed absolute step position

## Operation
- FSM states are IDLE, RUN and DONE. cmd_ready = (state == IDLE). busy = (state != IDLE).
- **IDLE:** on cmd_valid && cmd_ready:
  - latch dir, the remaining count (= cmd_steps) and the period P (= max(cmd_period, 2));
  - if cmd_steps == 0, go to DONE; otherwise go to RUN and load the divider with P-1.
- **RUN:** the divider counts down each cycle.
  - At 0: assert step, decrement remaining, reload the divider with P-1.
  - On the step that brings remaining to 0, go to DONE.
- **DONE:** lasts one cycle. Assert done, then go to IDLE.
- **position:** +1 (dir = 1) or -1 (dir = 0) on each step, registered. Wraps two's-complement.
- **abort:**
  - Sampled only in RUN. It has priority over a coincident divider-zero, so step is forced to 0 that cycle.
  - Next state is DONE with aborted = 1. aborted is cleared on the next command acceptance.
  - Ignored in IDLE and DONE. A cmd_valid coinciding with abort in IDLE is accepted normally.
- dir holds its last latched value while IDLE.

## Timing
- **Reset values:**
  - state IDLE; step 0, dir 0, busy 0, done 0, aborted 0, position 0;
  - cmd_ready 1 (combinational from state).
- Reset asserted mid-move clears everything immediately. No done pulse is produced.
- **Latency, handshake in cycle t, N ≥ 1:**
  - step pulses in cycles t+P, t+2P, …, t+N·P;
  - done in t+N·P+1; cmd_ready high in t+N·P+2.
- **N == 0:** done in t+1, cmd_ready in t+2, no step.
- position reflects a step in the cycle after the strobe.
- **Abort sampled in cycle a:** no step in cycle a or later; done in a+1; cmd_ready in a+2.

## Configuration
- Macro: STEP_RAMP_EN.
- **Defined:** acceleration ramp.
  - The first interval is cur = min(4·P, 2^DIV_W − 1).
  - After each step, cur = max(P, cur − (cur >> 3)).
  - The divider reloads with cur−1.
- **Undefined:** cur ≡ P and no ramp logic is synthesised.

## Structure
- Package step_cmd_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - MIN_PERIOD = 2, RAMP_MULT = 4, RAMP_SHIFT = 3.
- Sub-module step_rate_div: loadable down-counter with reload input and zero tick. The parent drives reload value and enable.

## Test plan
- **Reset:** rest_n low mid-RUN → all outputs at reset values immediately; cmd_ready = 1 after release; position = 0.
- **Forward move:** steps = 3, dir = 1, period = 5, accepted at t → step at t+5, t+10, t+15; done at t+16; position = 3; cmd_ready at t+17.
- **Zero count and clamp:**
  - steps = 0 → done at t+1, no step, position unchanged;
  - steps = 2, period = 0 → steps at t+2 and t+4.
- **Reverse and wrap:** position preset to 0 by reset, steps = 2, dir = 0, period = 3 → position = −2 (all-ones minus 1). A further forward move of 2 returns it to 0.
- **Abort:** steps = 10, period = 4, abort asserted in the cycle of the 3rd step → that step suppressed; done next cycle with aborted = 1; position = 2.
- **STEP_RAMP_EN defined:** steps = 4, period = 8 → step intervals 32, 28, 25, 22 cycles; position = 4.
